key_schedule_gen: RTL and testbench



---
 rtl/key_schedule_gen.sv | 201 ++++++++++++++++++++
 tb/tb_key_schedule_gen.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_schedule_gen.sv
// AES key expansion engine: one schedule word per cycle into a 60-word array,
// with independent combinational round-key read ports usable during expansion.

// Byte substitution: GF(2^8) inverse followed by the AES affine transform.
module aes_sbox (
   input  logic [7:0] a,
   output logic [7:0] y
);
   logic [7:0] sq;
   logic [7:0] inv;

   function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] z);
      logic [7:0] acc;
      logic [7:0] sh;
      acc = 8'h00;
      sh  = x;
      for (int i = 0; i < 8; i++) begin
         if (z[i]) acc = acc ^ sh;
         sh = {sh[6:0], 1'b0} ^ (8'h1b & {8{sh[7]}});
      end
      return acc;
   endfunction

   // Inverse as a^254 = a^2 * a^4 * ... * a^128 (maps 0 to 0), then affine map
   always_comb begin
      sq  = a;
      inv = 8'h01;
      for (int i = 0; i < 7; i++) begin
         sq  = gf_mul(sq, sq);
         inv = gf_mul(inv, sq);
      end
      y = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
          {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   end
endmodule

module key_schedule_gen #(
   parameter int unsigned READ_PORTS = 2,
   parameter bit          RESTART_EN = 1'b1
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      start,
   input  logic [1:0]                key_len,
   input  logic [255:0]              cipher_key,
   input  logic [READ_PORTS*4-1:0]   rd_addr,
   output logic [READ_PORTS*128-1:0] rd_key,
   output logic [READ_PORTS-1:0]     rd_valid,
   output logic                      busy,
   output logic                      done,
   output logic                      err,
   output logic [3:0]                num_rounds
);
   localparam int unsigned WORDS = 60;

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_EXPAND, S_DONE} state_t;

   state_t      state_q;
   state_t      state_d;
   logic [255:0] key_q;
   logic [3:0]  nk_q;
   logic [5:0]  wcnt_q;
   logic [2:0]  kidx_q;
   logic [7:0]  rcon_q;
   logic [31:0] w_mem [WORDS];

   logic        legal_start;
   logic        bad_start;
   logic        accept;
   logic        last_word;
   logic        busy_d;
   logic        done_d;
   logic [3:0]  nk_in;
   logic [3:0]  nr_in;
   logic [31:0] w_prev;
   logic [31:0] w_back;
   logic [31:0] sub_in;
   logic [31:0] sub_out;
   logic [31:0] temp;
   logic [31:0] w_new;
   logic [7:0]  rcon_next;

   // Next state, start qualification and key-size decode
   always_comb begin
      state_d     = state_q;
      accept      = 1'b0;
      nk_in       = 4'd8;
      nr_in       = 4'd14;
      legal_start = start && (key_len != 2'b11);
      bad_start   = start && (key_len == 2'b11);
      case (key_len)
         2'b00:   begin nk_in = 4'd4; nr_in = 4'd10; end
         2'b01:   begin nk_in = 4'd6; nr_in = 4'd12; end
         default: begin nk_in = 4'd8; nr_in = 4'd14; end
      endcase
      case (state_q)
         S_IDLE:   accept = legal_start;
         S_LOAD:   begin
            accept  = legal_start && RESTART_EN;
            state_d = S_EXPAND;
         end
         S_EXPAND: begin
            accept = legal_start && RESTART_EN;
            if (last_word) state_d = S_DONE;
         end
         S_DONE:   begin
            accept  = legal_start;
            state_d = S_IDLE;
         end
         default:  state_d = S_IDLE;
      endcase
      if (accept) state_d = S_LOAD;
      busy_d = (state_d == S_LOAD) || (state_d == S_EXPAND);
      done_d = (state_d == S_DONE);
   end

   // Final schedule word index is 4*(Nr+1)-1
   assign last_word = (wcnt_q == ({num_rounds, 2'b00} + 6'd3));

   assign w_prev    = w_mem[wcnt_q - 6'd1];
   assign w_back    = w_mem[wcnt_q - 6'(nk_q)];
   assign sub_in    = (kidx_q == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;
   assign rcon_next = {rcon_q[6:0], 1'b0} ^ (8'h1b & {8{rcon_q[7]}});

   for (genvar b = 0; b < 4; b++) begin : g_sbox
      aes_sbox u_sbox (
         .a (sub_in[8*b +: 8]),
         .y (sub_out[8*b +: 8])
      );
   end

   // New schedule word w[wcnt] from w[wcnt-1] and w[wcnt-Nk]
   always_comb begin
      temp = w_prev;
      if (kidx_q == 3'd0) begin
         temp = sub_out ^ {rcon_q, 24'h0};
      end else if ((nk_q == 4'd8) && (kidx_q == 3'd4)) begin
         temp = sub_out;
      end
      w_new = w_back ^ temp;
   end

   // State, counters, captured key and status flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         key_q      <= '0;
         nk_q       <= 4'd4;
         num_rounds <= '0;
         wcnt_q     <= '0;
         kidx_q     <= '0;
         rcon_q     <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
      end else begin
         state_q <= state_d;
         busy    <= busy_d;
         done    <= done_d;
         err     <= bad_start;
         if (accept) begin
            key_q      <= cipher_key;
            nk_q       <= nk_in;
            num_rounds <= nr_in;
            wcnt_q     <= '0;
         end else if (state_q == S_LOAD) begin
            wcnt_q <= 6'(nk_q);
            kidx_q <= '0;
            rcon_q <= 8'h01;
         end else if (state_q == S_EXPAND) begin
            wcnt_q <= wcnt_q + 6'd1;
            kidx_q <= (kidx_q == 3'(nk_q - 4'd1)) ? 3'd0 : kidx_q + 3'd1;
            if (kidx_q == 3'd0) rcon_q <= rcon_next;
         end
      end
   end

   // Word array: bulk key load in LOAD, one expanded word per EXPAND cycle
   always_ff @(posedge clk) begin
      if (state_q == S_LOAD) begin
         for (int i = 0; i < 8; i++) begin
            if (4'(i) < nk_q) w_mem[6'(i)] <= key_q[255-32*i -: 32];
         end
      end else if (state_q == S_EXPAND) begin
         w_mem[wcnt_q] <= w_new;
      end
   end

   // Read ports: a round is visible once its four words are written
   for (genvar p = 0; p < READ_PORTS; p++) begin : g_rd
      logic [3:0] addr;
      logic [5:0] base;
      logic       hit;
      assign addr        = rd_addr[4*p +: 4];
      assign base        = (addr <= 4'd14) ? {addr, 2'b00} : 6'd0;
      assign hit         = (addr <= num_rounds) && ({1'b0, wcnt_q} >= ({1'b0, base} + 7'd4));
      assign rd_valid[p] = hit;
      assign rd_key[128*p +: 128] = hit ? {w_mem[base], w_mem[base + 6'd1],
                                           w_mem[base + 6'd2], w_mem[base + 6'd3]} : 128'h0;
   end
endmodule

// File: tb/tb_key_schedule_gen.sv
// Self-checking bench for key_schedule_gen against a FIPS-197 style reference model.
module tb_key_schedule_gen;
   localparam int unsigned RP = 2;

   logic                clk;
   logic                rst_n;
   logic                start;
   logic [1:0]          key_len;
   logic [255:0]        cipher_key;
   logic [RP*4-1:0]     rd_addr;
   logic [RP*128-1:0]   rd_key;
   logic [RP-1:0]       rd_valid;
   logic                busy;
   logic                done;
   logic                err;
   logic [3:0]          num_rounds;

   int n_checks;
   int n_fail;

   logic [7:0]  sb [256];
   logic [7:0]  rc [16];
   logic [31:0] mw [60];
   int          m_nk;
   int          m_nr;

   key_schedule_gen #(.READ_PORTS(RP), .RESTART_EN(1'b1)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .key_len    (key_len),
      .cipher_key (cipher_key),
      .rd_addr    (rd_addr),
      .rd_key     (rd_key),
      .rd_valid   (rd_valid),
      .busy       (busy),
      .done       (done),
      .err        (err),
      .num_rounds (num_rounds)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Carry-less product reduced modulo x^8+x^4+x^3+x+1
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [14:0] prod;
      prod = '0;
      for (int i = 0; i < 8; i++) if (b[i]) prod = prod ^ (15'(a) << i);
      for (int k = 14; k >= 8; k--) if (prod[k]) prod = prod ^ (15'h11b << (k - 8));
      return prod[7:0];
   endfunction

   function automatic void build_tables();
      logic [7:0] inv;
      logic [7:0] s;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         for (int i = 0; i < 8; i++) begin
            s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8];
         end
         sb[x] = s ^ 8'h63;
      end
      rc[0] = 8'h00;
      rc[1] = 8'h01;
      for (int j = 2; j < 16; j++) rc[j] = gmul(rc[j-1], 8'h02);
   endfunction

   function automatic logic [31:0] subw(input logic [31:0] w);
      return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
   endfunction

   function automatic void model_expand(input logic [255:0] key, input logic [1:0] kl);
      logic [31:0] t;
      m_nk = 4 + 2 * int'(kl);
      m_nr = m_nk + 6;
      for (int i = 0; i < 60; i++) mw[i] = 32'h0;
      for (int i = 0; i < m_nk; i++) mw[i] = key[255-32*i -: 32];
      for (int i = m_nk; i < 4 * (m_nr + 1); i++) begin
         t = mw[i-1];
         if (i % m_nk == 0) t = subw({t[23:0], t[31:24]}) ^ {rc[i/m_nk], 24'h0};
         else if (m_nk > 6 && i % m_nk == 4) t = subw(t);
         mw[i] = mw[i-m_nk] ^ t;
      end
   endfunction

   function automatic logic [127:0] round_of(input int a);
      if (a > m_nr) return 128'h0;
      return {mw[4*a], mw[4*a+1], mw[4*a+2], mw[4*a+3]};
   endfunction

   // Cycle (counted from the start edge) at which round a first reads as valid
   function automatic int vstart(input int a);
      int last;
      last = 4 * a + 3;
      return (last < m_nk) ? 2 : last - m_nk + 3;
   endfunction

   function automatic logic [255:0] rand256();
      return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
   endfunction

   // One full expansion, checking every output on every cycle
   task automatic run_key(input string nm, input logic [255:0] key, input logic [1:0] kl,
                          input bit fixed, input int bad_at,
                          output int done_cyc, output int rise0, output int rise1);
      int ad [RP];
      int exp_done;
      bit ev;
      logic [127:0] ek;
      model_expand(key, kl);
      exp_done = 4 * (m_nr + 1) - m_nk + 2;
      done_cyc = -1;
      rise0    = -1;
      rise1    = -1;
      cipher_key = key;
      key_len    = kl;
      start      = 1'b1;
      tick();
      start      = 1'b0;
      cipher_key = rand256();
      for (int cyc = 1; cyc <= exp_done + 2; cyc++) begin
         for (int p = 0; p < RP; p++) begin
            ad[p] = fixed ? ((p == 0) ? 1 : 10) : int'($urandom_range(0, 15));
            rd_addr[4*p +: 4] = 4'(ad[p]);
         end
         #1;
         for (int p = 0; p < RP; p++) begin
            ev = (ad[p] <= m_nr) && (cyc >= vstart(ad[p]));
            ek = ev ? round_of(ad[p]) : 128'h0;
            chk($sformatf("%s valid p%0d a%0d c%0d", nm, p, ad[p], cyc), 128'(rd_valid[p]), 128'(ev));
            chk($sformatf("%s key p%0d a%0d c%0d", nm, p, ad[p], cyc), rd_key[128*p +: 128], ek);
            if (rd_valid[p] && p == 0 && rise0 < 0) rise0 = cyc;
            if (rd_valid[p] && p == 1 && rise1 < 0) rise1 = cyc;
         end
         chk($sformatf("%s done c%0d", nm, cyc), 128'(done), 128'(cyc == exp_done));
         chk($sformatf("%s busy c%0d", nm, cyc), 128'(busy), 128'(cyc < exp_done));
         chk($sformatf("%s err c%0d", nm, cyc), 128'(err), 128'(cyc == bad_at + 1));
         if (cyc == 1) chk({nm, " num_rounds"}, 128'(num_rounds), 128'(m_nr));
         if (done && done_cyc < 0) done_cyc = cyc;
         if (cyc == bad_at) begin
            start   = 1'b1;
            key_len = 2'b11;
         end
         tick();
         start = 1'b0;
      end
      chk({nm, " done_cycle"}, 128'(done_cyc), 128'(exp_done));
   endtask

   // Read every address on every port against the held schedule
   task automatic sweep(input string nm, input bit full);
      int ad [RP];
      bit ev;
      for (int a = 0; a < 16; a++) begin
         for (int p = 0; p < RP; p++) begin
            ad[p] = (a + 5 * p) % 16;
            rd_addr[4*p +: 4] = 4'(ad[p]);
         end
         #1;
         for (int p = 0; p < RP; p++) begin
            ev = full && (ad[p] <= m_nr);
            chk($sformatf("%s sweep valid p%0d a%0d", nm, p, ad[p]), 128'(rd_valid[p]), 128'(ev));
            chk($sformatf("%s sweep key p%0d a%0d", nm, p, ad[p]), rd_key[128*p +: 128],
                ev ? round_of(ad[p]) : 128'h0);
         end
      end
   endtask

   initial begin
      logic [255:0] k;
      logic [255:0] kr;
      logic [1:0]   kl;
      int dc, r0, r1, bad, seen;

      n_checks = 0;
      n_fail   = 0;
      build_tables();
      rst_n      = 1'b1;
      start      = 1'b0;
      key_len    = 2'b00;
      cipher_key = '0;
      rd_addr    = '0;
      #1 rst_n = 1'b0;
      #2;
      chk("rst busy", 128'(busy), 128'(0));
      chk("rst done", 128'(done), 128'(0));
      chk("rst err", 128'(err), 128'(0));
      chk("rst num_rounds", 128'(num_rounds), 128'(0));
      chk("rst rd_valid", 128'(rd_valid), 128'(0));
      chk("rst rd_key0", rd_key[127:0], 128'h0);
      @(posedge clk);
      @(posedge clk);
      #2 rst_n = 1'b1;
      tick();

      // AES-128 known vector with overlap ports at rounds 1 and 10
      kr = rand256();
      k  = {128'h2b7e151628aed2a6abf7158809cf4f3c, kr[127:0]};
      run_key("aes128", k, 2'b00, 1'b1, -1, dc, r0, r1);
      chk("ovl port0 rise", 128'(r0), 128'(6));
      chk("ovl port1 rise", 128'(r1), 128'(42));
      chk("aes128 round10", round_of(10), 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
      rd_addr[3:0] = 4'd10;
      rd_addr[7:4] = 4'd11;
      #1;
      chk("aes128 rd r10", rd_key[127:0], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
      chk("aes128 a11 valid", 128'(rd_valid[1]), 128'(0));
      chk("aes128 a11 key", rd_key[255:128], 128'h0);
      chk("aes128 num_rounds", 128'(num_rounds), 128'(10));
      sweep("aes128", 1'b1);

      // AES-192 known vector
      kr = rand256();
      k  = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, kr[63:0]};
      run_key("aes192", k, 2'b01, 1'b0, -1, dc, r0, r1);
      chk("aes192 round12", round_of(12), 128'he98ba06f448c773c8ecc720401002202);
      chk("aes192 num_rounds", 128'(num_rounds), 128'(12));
      sweep("aes192", 1'b1);

      // AES-256 known vector, then a rejected reserved-length start
      k = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
      run_key("aes256", k, 2'b10, 1'b0, -1, dc, r0, r1);
      chk("aes256 round14", round_of(14), 128'hfe4890d1e6188d0b046df344706c631e);
      cipher_key = rand256();
      key_len    = 2'b11;
      start      = 1'b1;
      tick();
      start = 1'b0;
      chk("err pulse", 128'(err), 128'(1));
      chk("err busy", 128'(busy), 128'(0));
      chk("err num_rounds", 128'(num_rounds), 128'(14));
      tick();
      chk("err single", 128'(err), 128'(0));
      sweep("after_err", 1'b1);

      // Restart: AES-256 aborted at cycle 20 by an AES-128 start
      cipher_key = rand256();
      key_len    = 2'b10;
      start      = 1'b1;
      tick();
      start = 1'b0;
      for (int cyc = 1; cyc < 20; cyc++) begin
         chk($sformatf("restart pre done c%0d", cyc), 128'(done), 128'(0));
         tick();
      end
      run_key("restart128", rand256(), 2'b00, 1'b0, -1, dc, r0, r1);
      sweep("restart128", 1'b1);

      // Randomized keys and sizes, some with a reserved start mid-expansion
      repeat (4) begin
         kl  = 2'($urandom_range(0, 2));
         bad = ($urandom_range(0, 1) == 1) ? int'($urandom_range(3, 30)) : -1;
         run_key("rand", rand256(), kl, 1'b0, bad, dc, r0, r1);
         sweep("rand", 1'b1);
      end

      // Reset in the middle of an expansion
      cipher_key = rand256();
      key_len    = 2'b00;
      start      = 1'b1;
      tick();
      start = 1'b0;
      repeat (14) tick();
      rd_addr = '0;
      #2 rst_n = 1'b0;
      #1;
      chk("midrst busy", 128'(busy), 128'(0));
      chk("midrst done", 128'(done), 128'(0));
      chk("midrst err", 128'(err), 128'(0));
      chk("midrst num_rounds", 128'(num_rounds), 128'(0));
      chk("midrst rd_valid", 128'(rd_valid), 128'(0));
      chk("midrst rd_key0", rd_key[127:0], 128'h0);
      @(posedge clk);
      #2 rst_n = 1'b1;
      seen = 0;
      repeat (60) begin
         tick();
         if (done) seen++;
      end
      chk("midrst no done", 128'(seen), 128'(0));
      chk("midrst idle busy", 128'(busy), 128'(0));
      sweep("midrst", 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
